// File: rtl/mem_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_queue_pkg                                                              |
// | Shared types for the memory-stage load/store queue and the dbus protocol.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_queue_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    localparam logic [4:0] EX_ADEL = 5'h04;
    localparam logic [4:0] EX_ADES = 5'h05;

    // Upper bound on the opaque tag width; the queue keeps the low TAG_W bits.
    localparam int unsigned TAG_W_MAX = 16;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic [31:0]          addr;
        msize_t               msize;
        logic                 write;
        logic                 sgn;
        logic [31:0]          wdata;
        logic [TAG_W_MAX-1:0] tag;
        logic                 exc;
        logic                 done;
        logic                 killed;
        logic [31:0]          rdata;
    } mem_entry_t;

    function automatic logic MISALIGN(input msize_t sz, input logic [1:0] lo);
        case (sz)
            MSIZE2:  MISALIGN = lo[0];
            MSIZE4:  MISALIGN = |lo;
            default: MISALIGN = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_lane_align                                                             |
// | Store lane replication/strobe and load byte extraction with extension.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_lane_align
    import mem_queue_pkg::*;
(
    input  logic [1:0]  st_off,
    input  msize_t      st_size,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_strobe,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_off,
    input  msize_t      ld_size,
    input  logic        ld_signed,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    always_comb begin
        st_strobe = 4'hF;
        st_data   = st_wdata;
        case (st_size)
            MSIZE1: begin
                st_strobe = 4'b0001 << st_off;
                st_data   = {4{st_wdata[7:0]}};
            end
            MSIZE2: begin
                st_strobe = 4'b0011 << st_off;
                st_data   = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_shift = ld_raw >> {ld_off, 3'b000};
        ld_data  = ld_shift;
        case (ld_size)
            MSIZE1:  ld_data = {{24{ld_signed & ld_shift[7]}},  ld_shift[7:0]};
            MSIZE2:  ld_data = {{16{ld_signed & ld_shift[15]}}, ld_shift[15:0]};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_req_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_req_queue                                                              |
// | In-order load/store queue with overlapping dbus requests and in-order      |
// | retirement of load data, store acks and alignment faults.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_req_queue
    import mem_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_write,
    input  logic [31:0]      in_addr,
    input  msize_t           in_msize,
    input  logic             in_signed,
    input  logic [31:0]      in_wdata,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output dbus_req_t        dreq,
    input  dbus_resp_t       dresp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_exc,
    output logic [4:0]       out_exc_code,
    output logic [31:0]      out_badvaddr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] dptr_q, dptr_d;
    logic [PW-1:0] iptr_q, iptr_d;
    logic [PW-1:0] tail_q, tail_d;
    mem_entry_t    ent_q [DEPTH];
    mem_entry_t    ent_d [DEPTH];

    logic [AW-1:0] hslot, dslot, islot, tslot;
    logic [PW-1:0] count, outstanding, kill_span;
    logic [AW-1:0] slot_off [DEPTH];
    logic          full, empty;
    logic          req_valid, issue, complete;
    logic          head_ok, pop, fence_pass, push;
    logic [3:0]    st_strobe;
    logic [31:0]   st_data, ld_data;

    assign hslot = head_q[AW-1:0];
    assign dslot = dptr_q[AW-1:0];
    assign islot = iptr_q[AW-1:0];
    assign tslot = tail_q[AW-1:0];

    assign count       = tail_q - head_q;
    assign outstanding = iptr_q - dptr_q;
    assign kill_span   = iptr_q - head_q;
    assign full        = (count == PW'(DEPTH));
    assign empty       = (head_q == tail_q);

    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;

    // A faulted entry at iptr blocks issue of itself and everything behind it.
    assign req_valid = (iptr_q != tail_q) && !ent_q[islot].exc
                       && (outstanding < PW'(MAX_OUT)) && !flush;
    assign issue     = req_valid && dresp.addr_ok;
    assign complete  = dresp.data_ok && ((dptr_q != iptr_q) || issue);

    assign head_ok    = !empty && ent_q[hslot].done;
    assign out_valid  = head_ok && !ent_q[hslot].killed;
    assign pop        = head_ok && (ent_q[hslot].killed || out_ready);
    // Only an unissued faulted entry can be done at head while head == iptr.
    assign fence_pass = pop && (head_q == iptr_q);

    mem_lane_align u_align (
        .st_off    (ent_q[islot].addr[1:0]),
        .st_size   (ent_q[islot].msize),
        .st_wdata  (ent_q[islot].wdata),
        .st_strobe (st_strobe),
        .st_data   (st_data),
        .ld_off    (ent_q[dslot].addr[1:0]),
        .ld_size   (ent_q[dslot].msize),
        .ld_signed (ent_q[dslot].sgn),
        .ld_raw    (dresp.data),
        .ld_data   (ld_data)
    );

    always_comb begin
        dreq.valid  = req_valid;
        dreq.addr   = req_valid ? ent_q[islot].addr  : 32'h0;
        dreq.size   = req_valid ? ent_q[islot].msize : MSIZE1;
        dreq.strobe = req_valid ? st_strobe          : 4'h0;
        dreq.data   = req_valid ? st_data            : 32'h0;
    end

    always_comb begin
        out_data     = 32'h0;
        out_tag      = '0;
        out_exc      = 1'b0;
        out_exc_code = 5'h0;
        out_badvaddr = 32'h0;
        if (out_valid) begin
            out_data = ent_q[hslot].rdata;
            out_tag  = ent_q[hslot].tag[TAG_W-1:0];
            out_exc  = ent_q[hslot].exc;
            if (ent_q[hslot].exc) begin
                out_exc_code = ent_q[hslot].write ? EX_ADES : EX_ADEL;
                out_badvaddr = ent_q[hslot].addr;
            end
        end
    end

    always_comb begin
        head_d = head_q + PW'(pop);
        iptr_d = iptr_q + PW'(issue || fence_pass);
        dptr_d = dptr_q + PW'(complete || fence_pass);
        tail_d = flush ? iptr_d : tail_q + PW'(push);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_off[i] = AW'(i) - hslot;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            // Issued entries survive a flush but must retire invisibly.
            if (flush && ({1'b0, slot_off[i]} < kill_span)) begin
                ent_d[i].killed = 1'b1;
            end
        end
        if (push) begin
            ent_d[tslot].addr   = in_addr;
            ent_d[tslot].msize  = in_msize;
            ent_d[tslot].write  = in_write;
            ent_d[tslot].sgn    = in_signed;
            ent_d[tslot].wdata  = in_wdata;
            ent_d[tslot].tag    = TAG_W_MAX'(in_tag);
            ent_d[tslot].exc    = MISALIGN(in_msize, in_addr[1:0]);
            ent_d[tslot].done   = MISALIGN(in_msize, in_addr[1:0]);
            ent_d[tslot].killed = 1'b0;
            ent_d[tslot].rdata  = 32'h0;
        end
        if (complete) begin
            ent_d[dslot].done  = 1'b1;
            ent_d[dslot].rdata = ent_q[dslot].write ? 32'h0 : ld_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            dptr_q <= '0;
            iptr_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            dptr_q <= dptr_d;
            iptr_q <= iptr_d;
            tail_q <= tail_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

`ifndef SYNTHESIS
    a_no_stray_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        dresp.data_ok |-> ((dptr_q != iptr_q) || issue))
        else $error("data_ok with no outstanding request");
`endif

endmodule
`default_nettype wire
